// File: rtl/sseg_pkg.sv
// Shared glyph table and sizing helpers for the multiplexed seven-segment driver.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // One PWM slot per brightness code; never narrower than a single bit.
    function automatic int slot_width(input int bright_w);
        return (bright_w < 1) ? 1 : bright_w;
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Scan timebase: per-digit dwell counter, digit index, frame tick, blink phase
// and the PWM slot within the current dwell.
module sseg_scan_timer
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL        = 50000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    output logic [$clog2(DWELL)-1:0]          o_dwell_cnt,
    output logic [$clog2(NUM_DIGITS)-1:0]     o_idx,
    output logic                              o_frame_tick,
    output logic                              o_blink_phase,
    output logic [slot_width(BRIGHT_W)-1:0]   o_slot
);

    localparam int DWELL_W  = $clog2(DWELL);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int SLOT_W   = slot_width(BRIGHT_W);
    localparam int SLOT_LEN = DWELL >> BRIGHT_W;
    localparam int SUB_W    = $clog2(SLOT_LEN + 1);
    localparam int BLINK_W  = $clog2(BLINK_FRAMES + 1);

    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [SUB_W-1:0]   r_sub_cnt;
    logic [SLOT_W-1:0]  r_slot;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    logic w_dwell_end;
    logic w_idx_last;
    logic w_frame_end;

    assign w_dwell_end = (r_dwell_cnt == DWELL_W'(DWELL - 1));
    assign w_idx_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
    // Gated by reset so no tick (and hence no commit/ack) escapes a reset cycle.
    assign w_frame_end = w_dwell_end && w_idx_last && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dwell_cnt   <= '0;
            r_idx         <= '0;
            r_sub_cnt     <= '0;
            r_slot        <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_dwell_cnt <= w_dwell_end ? '0 : r_dwell_cnt + DWELL_W'(1);
            // Slot counter runs beside dwell_cnt so no divider is needed.
            if (w_dwell_end) begin
                r_sub_cnt <= '0;
                r_slot    <= '0;
            end else if (r_sub_cnt == SUB_W'(SLOT_LEN - 1)) begin
                r_sub_cnt <= '0;
                r_slot    <= r_slot + SLOT_W'(1);
            end else begin
                r_sub_cnt <= r_sub_cnt + SUB_W'(1);
            end
            if (w_dwell_end) begin
                r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
            if (w_frame_end) begin
                if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    assign o_dwell_cnt   = r_dwell_cnt;
    assign o_idx         = r_idx;
    assign o_frame_tick  = w_frame_end;
    assign o_blink_phase = r_blink_phase;
    assign o_slot        = r_slot;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver with double-buffered display data, leading-zero
// suppression, per-digit blank/blink, PWM brightness and an anti-ghost dead cycle.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL        = 50000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 250,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk_50M,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_tick,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int   DWELL_W = $clog2(DWELL);
    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam int   SLOT_W  = slot_width(BRIGHT_W);
    localparam logic LOW     = (ACTIVE_LOW != 0);

    logic [DWELL_W-1:0] w_dwell_cnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_frame_tick;
    logic               w_blink_phase;
    logic [SLOT_W-1:0]  w_slot;

    sseg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DWELL       (DWELL),
        .BRIGHT_W    (BRIGHT_W),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .i_clk        (clk_50M),
        .i_rst        (reset),
        .o_dwell_cnt  (w_dwell_cnt),
        .o_idx        (w_idx),
        .o_frame_tick (w_frame_tick),
        .o_blink_phase(w_blink_phase),
        .o_slot       (w_slot)
    );

    logic [4*NUM_DIGITS-1:0] r_pend_data, r_shd_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_shd_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_shd_blank;
    logic [NUM_DIGITS-1:0]   r_pend_blink, r_shd_blink;
    logic                    r_pend_lz, r_shd_lz;
    logic                    r_pending;

    // A load in the frame-end cycle lands in pending after the old pending commits.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_blink <= '0;
            r_pend_lz    <= 1'b0;
            r_shd_data   <= '0;
            r_shd_dp     <= '0;
            r_shd_blank  <= '0;
            r_shd_blink  <= '0;
            r_shd_lz     <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (w_frame_tick && r_pending) begin
                r_shd_data  <= r_pend_data;
                r_shd_dp    <= r_pend_dp;
                r_shd_blank <= r_pend_blank;
                r_shd_blink <= r_pend_blink;
                r_shd_lz    <= r_pend_lz;
                r_pending   <= 1'b0;
            end
            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_blink <= blink_in;
                r_pend_lz    <= lz_suppress;
                r_pending    <= 1'b1;
            end
        end
    end

    assign frame_tick = w_frame_tick;
    assign load_ack   = w_frame_tick && r_pending;

    logic [3:0]            w_digit;
    logic                  w_upper_zero;
    logic                  w_lz;
    logic                  w_dark;
    logic                  w_lit;
    logic [6:0]            w_glyph;
    logic [7:0]            w_seg_on;
    logic [NUM_DIGITS-1:0] w_an_on;

    assign w_digit      = r_shd_data[{w_idx, 2'b00} +: 4];
    assign w_upper_zero = ((r_shd_data >> {w_idx, 2'b00}) == '0);
    assign w_lz         = r_shd_lz && w_upper_zero && (w_idx != '0);
    assign w_dark       = r_shd_blank[w_idx] || (r_shd_blink[w_idx] && w_blink_phase);
    // A suppressed leading zero keeps its anode only to show a lit decimal point.
    assign w_lit        = !w_dark && (w_dwell_cnt != '0) && (w_slot <= SLOT_W'(brightness))
                          && (!w_lz || r_shd_dp[w_idx]);
    assign w_glyph      = w_lz ? SEG_BLANK : hex_to_seg(w_digit);
    assign w_seg_on     = w_lit ? {r_shd_dp[w_idx], w_glyph} : 8'h00;
    assign w_an_on      = w_lit ? (NUM_DIGITS'(1) << w_idx) : '0;

    logic [7:0]            r_sseg;
    logic [NUM_DIGITS-1:0] r_an;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_sseg <= {8{LOW}};
            r_an   <= {NUM_DIGITS{LOW}};
        end else begin
            r_sseg <= w_seg_on ^ {8{LOW}};
            r_an   <= w_an_on ^ {NUM_DIGITS{LOW}};
        end
    end

    assign sseg = r_sseg;
    assign an   = r_an;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver: a per-cycle reference model feeds a
// scoreboard of expected pin values, plus directed checks on the scan scenarios.
module tb_sseg_scan_driver;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int BF = 2;
    localparam int SLOT_LEN = DW / (1 << BW);
    localparam int FRAME = DW * ND;

    logic        clk_50M = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  blink_in = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic        load = 1'b0;
    logic        load_ack;
    logic        frame_tick;
    logic [7:0]  sseg;
    logic [3:0]  an;

    sseg_scan_driver #(
        .NUM_DIGITS(ND), .DWELL(DW), .BRIGHT_W(BW), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .data(data), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_suppress(lz_suppress),
        .brightness(brightness), .load(load), .load_ack(load_ack),
        .frame_tick(frame_tick), .sseg(sseg), .an(an)
    );

    always #5 clk_50M = ~clk_50M;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_chk = 0;
    int n_fail = 0;
    int n_ack = 0;
    int n_lit = 0;
    int n_d0 = 0;
    int cyc = 0;
    int last_idx = -1;
    int last_dw = -1;
    logic [11:0] sb [$];

    logic        m_pend = 1'b0;
    logic [15:0] m_pdata = '0, m_sdata = '0;
    logic [3:0]  m_pdp = '0, m_sdp = '0;
    logic [3:0]  m_pblank = '0, m_sblank = '0;
    logic [3:0]  m_pblink = '0, m_sblink = '0;
    logic        m_plz = 1'b0, m_slz = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: check combinational strobes, queue expected pins, clock, compare, advance model.
    task automatic step();
        int dw, ix, fr;
        bit ph, fend, lzd, on;
        logic [3:0]  nib, e_an;
        logic [7:0]  e_seg;
        logic [11:0] exp;
        dw = cyc % DW;
        ix = (cyc / DW) % ND;
        fr = cyc / FRAME;
        ph = ((fr / BF) % 2) == 1;
        fend = (dw == DW - 1) && (ix == ND - 1);
        if (reset) begin
            chk("frame_tick_in_reset", frame_tick, 1'b0);
            chk("load_ack_in_reset", load_ack, 1'b0);
            e_an = 4'hF;
            e_seg = 8'hFF;
        end else begin
            chk("frame_tick", frame_tick, fend);
            chk("load_ack", load_ack, fend && m_pend);
            nib = m_sdata[4*ix +: 4];
            lzd = m_slz && (ix != 0) && ((m_sdata >> (4*ix)) == 16'h0);
            on = !m_sblank[ix] && !(m_sblink[ix] && ph) && (dw != 0)
                 && ((dw / SLOT_LEN) <= int'(brightness)) && (!lzd || m_sdp[ix]);
            e_an = on ? ~(4'b0001 << ix) : 4'hF;
            e_seg = on ? ~{m_sdp[ix], (lzd ? 7'h00 : glyph[nib])} : 8'hFF;
        end
        if (load_ack === 1'b1) n_ack++;
        sb.push_back({e_an, e_seg});
        @(posedge clk_50M);
        #1;
        exp = sb.pop_front();
        chk("an", an, exp[11:8]);
        chk("sseg", sseg, exp[7:0]);
        if (an != 4'hF) n_lit++;
        if (an[0] == 1'b0) n_d0++;
        last_idx = ix;
        last_dw = dw;
        if (reset) begin
            m_pend = 1'b0;
            m_pdata = '0; m_pdp = '0; m_pblank = '0; m_pblink = '0; m_plz = 1'b0;
            m_sdata = '0; m_sdp = '0; m_sblank = '0; m_sblink = '0; m_slz = 1'b0;
            cyc = 0;
        end else begin
            if (fend && m_pend) begin
                m_sdata = m_pdata; m_sdp = m_pdp; m_sblank = m_pblank;
                m_sblink = m_pblink; m_slz = m_plz; m_pend = 1'b0;
            end
            if (load) begin
                m_pdata = data; m_pdp = dp_in; m_pblank = blank_in;
                m_pblink = blink_in; m_plz = lz_suppress; m_pend = 1'b1;
            end
            cyc++;
        end
    endtask

    // Runs until the pins show the given digit/dwell position.
    task automatic run_to(input int i, input int d);
        for (int k = 0; k < 4 * FRAME; k++) begin
            step();
            if (last_idx == i && last_dw == d) return;
        end
        chk("run_to_timeout", 0, 1);
    endtask

    task automatic to_frame_start();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (cyc % FRAME == 0) return;
            step();
        end
        chk("frame_start_timeout", 0, 1);
    endtask

    task automatic do_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    int lit_frames;

    initial begin
        repeat (2) @(posedge clk_50M);
        #1;
        step();
        chk("reset_an", an, 4'hF);
        chk("reset_sseg", sseg, 8'hFF);
        reset = 1'b0;

        // Basic scan of 12AF at full brightness
        data = 16'h12AF; brightness = 2'd3;
        n_ack = 0;
        do_load();
        while (cyc < FRAME) step();
        chk("t1_ack_count", n_ack, 1);
        run_to(0, 0); chk("t1_dead_an", an, 4'hF);
        run_to(0, 5); chk("t1_d0_an", an, 4'b1110); chk("t1_d0_seg", sseg[6:0], 7'b0001110);
        run_to(1, 5); chk("t1_d1_an", an, 4'b1101); chk("t1_d1_seg", sseg[6:0], 7'b0001000);
        run_to(2, 5); chk("t1_d2_an", an, 4'b1011); chk("t1_d2_seg", sseg[6:0], 7'b0100100);
        run_to(3, 5); chk("t1_d3_an", an, 4'b0111); chk("t1_d3_seg", sseg[6:0], 7'b1111001);

        // Leading-zero suppression with a dp on a suppressed digit
        data = 16'h0042; lz_suppress = 1'b1; dp_in = 4'b1000;
        do_load();
        to_frame_start();
        run_to(0, 5); chk("t2_d0_an", an, 4'b1110); chk("t2_d0_seg", sseg[6:0], 7'b0100100);
        run_to(1, 5); chk("t2_d1_an", an, 4'b1101); chk("t2_d1_seg", sseg[6:0], 7'b0011001);
        run_to(2, 5); chk("t2_d2_an", an, 4'hF);
        run_to(3, 5); chk("t2_d3_an", an, 4'b0111); chk("t2_d3_seg", sseg, 8'b0111_1111);

        // Last-wins pending buffer, then a load exactly in the frame-end cycle
        lz_suppress = 1'b0; dp_in = 4'h0;
        data = 16'h1111; do_load();
        repeat (5) step();
        data = 16'h2222; n_ack = 0; do_load();
        to_frame_start();
        chk("t3_single_ack", n_ack, 1);
        run_to(0, 5); chk("t3_d0_seg", sseg[6:0], 7'b0100100);
        run_to(3, 5); chk("t3_d3_seg", sseg[6:0], 7'b0100100);
        while (cyc % FRAME != FRAME - 1) step();
        data = 16'h3333; n_ack = 0;
        do_load();
        chk("t3_defer_no_ack", n_ack, 0);
        run_to(0, 5); chk("t3_defer_old_seg", sseg[6:0], 7'b0100100);
        to_frame_start();
        chk("t3_defer_ack", n_ack, 1);
        run_to(0, 5); chk("t3_defer_new_seg", sseg[6:0], 7'b0110000);

        // Reduced brightness: slots 0-1 only, minus the dead cycle
        brightness = 2'd1;
        to_frame_start();
        n_lit = 0;
        repeat (FRAME) step();
        chk("t4_lit_cycles", n_lit, 28);
        run_to(0, 7); chk("t4_dw7_an", an, 4'b1110);
        run_to(0, 8); chk("t4_dw8_an", an, 4'hF);
        brightness = 2'd3;

        // Blink on digit 0 only
        data = 16'h1234; blink_in = 4'b0001;
        do_load();
        to_frame_start();
        lit_frames = 0;
        for (int f = 0; f < 4; f++) begin
            n_d0 = 0; n_lit = 0;
            repeat (FRAME) step();
            if (n_d0 > 0) lit_frames++;
            chk("t5_other_digits", n_lit - n_d0, 3 * (DW - 1));
        end
        chk("t5_blink_frames", lit_frames, 2);

        // Reset with a load pending discards it
        blink_in = 4'h0; data = 16'h9999;
        do_load();
        repeat (3) step();
        reset = 1'b1; n_ack = 0;
        step();
        chk("t6_an", an, 4'hF);
        chk("t6_sseg", sseg, 8'hFF);
        reset = 1'b0;
        repeat (2 * FRAME) step();
        chk("t6_no_ack", n_ack, 0);
        run_to(0, 5); chk("t6_d0_an", an, 4'b1110); chk("t6_d0_seg", sseg[6:0], 7'b1000000);
        run_to(3, 5); chk("t6_d3_an", an, 4'b0111); chk("t6_d3_seg", sseg[6:0], 7'b1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
